row_requant_collector: RTL and testbench

// Downstream stage of one systolic MAC row: consumes the accumulated partial sum leaving the east edge
// of the last column block and requantises it back to datawidth. Operations, in order: bias add,

---
 rtl/row_requant_collector.sv | 165 ++++++++++++++++
 tb/tb_row_requant_collector.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/row_requant_collector.sv
// Requantises systolic row sums (bias, ReLU, rounding shift, saturation) into a
// show-ahead output FIFO with credit-based admission and a valid/ready drain.
module row_requant_collector #(
  parameter int datawidth = 11,
  parameter int columns   = 64,
  parameter int DEPTH     = 8,
  localparam int ACCW     = 2*datawidth + $clog2(columns)
) (
  input  logic                 clk,
  input  logic                 rst_overall,
  input  logic                 rst_vals,
  input  logic [ACCW-1:0]      acc_in,
  input  logic                 acc_valid,
  input  logic                 cfg_load,
  input  logic [ACCW-1:0]      bias,
  input  logic [4:0]           shift,
  input  logic                 relu_en,
  output logic [datawidth-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 fifo_full,
  output logic                 drop,
  output logic [15:0]          overflow_cnt
);

  localparam int BW = ACCW + 1;
  localparam int QW = ACCW + 2;
  localparam int TW = ACCW + 6;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic signed [QW-1:0] QMAX = QW'(2**(datawidth-1) - 1);
  localparam logic signed [QW-1:0] QMIN = ~QMAX;

  logic [ACCW-1:0]             bias_r;
  logic [4:0]                  shift_r;
  logic                        relu_r;

  logic                        s1_v, s2_v, s3_v;
  logic [BW-1:0]               s1_b;
  logic [4:0]                  s1_shift;
  logic                        s1_relu;
  logic signed [QW-1:0]        s2_q;
  logic [datawidth-1:0]        s3_data;

  logic [datawidth-1:0]        mem [DEPTH];
  logic [PW-1:0]               wr_ptr, rd_ptr;
  logic [CW-1:0]               count, count_next, occ;

  logic                        accept, push, pop, sat_hi, sat_lo, head_load;
  logic [BW-1:0]               b_next;
  logic signed [BW-1:0]        r;
  logic signed [TW-1:0]        t, half, tq;
  logic signed [QW-1:0]        q_next;
  logic [datawidth-1:0]        sat, head_next;

  assign out_valid = (count != '0);
  assign fifo_full = (count == CW'(DEPTH));
  assign push      = s3_v;
  assign pop       = out_valid && out_ready;

  // Credit uses registered occupancy only, so a same-cycle pop never frees a slot.
  assign occ    = count + CW'(s1_v) + CW'(s2_v) + CW'(s3_v);
  assign accept = acc_valid && (occ < CW'(DEPTH));
  assign b_next = {acc_in[ACCW-1], acc_in} + {bias_r[ACCW-1], bias_r};

  always_comb begin
    r    = (s1_relu && s1_b[BW-1]) ? '0 : s1_b;
    t    = {{(TW-BW){r[BW-1]}}, r};
    half = (s1_shift == 5'd0) ? '0 : (TW'(1) << (s1_shift - 5'd1));
    // Extra headroom keeps the rounding constant exact even for shift=31.
    tq     = (t + half) >>> s1_shift;
    q_next = QW'(tq);
  end

  always_comb begin
    sat_hi = (s2_q > QMAX);
    sat_lo = (s2_q < QMIN);
    if (sat_hi)      sat = {1'b0, {(datawidth-1){1'b1}}};
    else if (sat_lo) sat = {1'b1, {(datawidth-1){1'b0}}};
    else             sat = s2_q[datawidth-1:0];
  end

  // out_data is a register tracking the head that will be present after this edge.
  always_comb begin
    head_next = out_data;
    head_load = 1'b0;
    if (push && (count == '0 || (pop && count == CW'(1)))) begin
      head_next = s3_data;
      head_load = 1'b1;
    end else if (pop && count > CW'(1)) begin
      head_next = mem[rd_ptr + PW'(1)];
      head_load = 1'b1;
    end
  end

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push && !rst_vals) mem[wr_ptr] <= s3_data;
  end

  always_ff @(posedge clk or posedge rst_overall) begin
    if (rst_overall) begin
      bias_r       <= '0;
      shift_r      <= '0;
      relu_r       <= 1'b0;
      overflow_cnt <= '0;
      s1_v         <= 1'b0;
      s2_v         <= 1'b0;
      s3_v         <= 1'b0;
      s1_b         <= '0;
      s1_shift     <= '0;
      s1_relu      <= 1'b0;
      s2_q         <= '0;
      s3_data      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      drop         <= 1'b0;
      out_data     <= '0;
    end else begin
      if (cfg_load) begin
        bias_r  <= bias;
        shift_r <= shift;
        relu_r  <= relu_en;
      end
      if (s2_v && (sat_hi || sat_lo) && !rst_vals && overflow_cnt != '1)
        overflow_cnt <= overflow_cnt + 16'd1;
      if (accept) begin
        s1_b     <= b_next;
        s1_shift <= shift_r;
        s1_relu  <= relu_r;
      end
      s2_q    <= q_next;
      s3_data <= sat;
      if (rst_vals) begin
        s1_v     <= 1'b0;
        s2_v     <= 1'b0;
        s3_v     <= 1'b0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        drop     <= 1'b0;
        out_data <= '0;
      end else begin
        s1_v  <= accept;
        s2_v  <= s1_v;
        s3_v  <= s2_v;
        drop  <= acc_valid && !accept;
        count <= count_next;
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        if (head_load) out_data <= head_next;
      end
    end
  end

endmodule

// File: tb/tb_row_requant_collector.sv
// Directed self-checking bench for row_requant_collector at datawidth=11, columns=64, DEPTH=8.
module tb_row_requant_collector;

  localparam int DW    = 11;
  localparam int COLS  = 64;
  localparam int DEPTH = 8;
  localparam int ACCW  = 28;

  logic                   clk = 1'b0;
  logic                   rst_overall = 1'b1;
  logic                   rst_vals = 1'b0;
  logic signed [ACCW-1:0] acc_in = '0;
  logic                   acc_valid = 1'b0;
  logic                   cfg_load = 1'b0;
  logic signed [ACCW-1:0] bias = '0;
  logic [4:0]             shift = '0;
  logic                   relu_en = 1'b0;
  logic [DW-1:0]          out_data;
  logic                   out_valid;
  logic                   out_ready = 1'b1;
  logic                   fifo_full;
  logic                   drop;
  logic [15:0]            overflow_cnt;

  int tests = 0;
  int fails = 0;

  row_requant_collector #(.datawidth(DW), .columns(COLS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_overall(rst_overall), .rst_vals(rst_vals),
    .acc_in(acc_in), .acc_valid(acc_valid), .cfg_load(cfg_load),
    .bias(bias), .shift(shift), .relu_en(relu_en),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_full(fifo_full), .drop(drop), .overflow_cnt(overflow_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic signed [ACCW-1:0] b, input logic [4:0] s, input logic rl);
    bias = b; shift = s; relu_en = rl; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  // Sends one sample with out_ready high, returns the first head seen (bounded wait) and lets it pop.
  task automatic run_one(input logic signed [ACCW-1:0] v, output logic [DW-1:0] d, output bit got);
    acc_in = v; acc_valid = 1'b1;
    tick();
    acc_valid = 1'b0;
    got = 1'b0; d = '0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (out_valid) begin got = 1'b1; d = out_data; end
      else tick();
    end
    if (got) tick();
  endtask

  task automatic test_reset;
    rst_overall = 1'b1;
    tick(); tick();
    tests++;
    if ({out_data, out_valid, fifo_full, drop, overflow_cnt} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got data=%0d valid=%0b full=%0b drop=%0b ovf=%0d, want all 0",
               out_data, out_valid, fifo_full, drop, overflow_cnt);
    end
    @(negedge clk) rst_overall = 1'b0;
    tick();
    tests++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      fails++;
      $display("FAIL reset_release: got valid=%0b data=%0d, want 0 0", out_valid, out_data);
    end
  endtask

  task automatic test_passthrough_latency;
    logic [3:0] seen;
    out_ready = 1'b1;
    set_cfg(0, 0, 0);
    acc_in = 500; acc_valid = 1'b1;
    tick();
    acc_valid = 1'b0;
    seen[0] = out_valid;
    tick(); seen[1] = out_valid;
    tick(); seen[2] = out_valid;
    tick(); seen[3] = out_valid;
    tests++;
    if (seen !== 4'b1000 || $signed(out_data) !== 11'sd500) begin
      fails++;
      $display("FAIL latency_500: valid after N..N+3=%b data=%0d, want 1000 500", seen, $signed(out_data));
    end
    tick();
    tests++;
    if (out_valid !== 1'b0 || $signed(out_data) !== 11'sd500) begin
      fails++;
      $display("FAIL single_pop: got valid=%0b data=%0d, want 0 500", out_valid, $signed(out_data));
    end
  endtask

  task automatic test_saturation;
    logic [DW-1:0] d;
    bit got;
    set_cfg(0, 4, 0);
    run_one(100000, d, got);
    tests++;
    if (!got || $signed(d) !== 11'sd1023 || overflow_cnt !== 16'd1) begin
      fails++;
      $display("FAIL sat_pos: got=%0b data=%0d ovf=%0d, want 1023 ovf=1", got, $signed(d), overflow_cnt);
    end
    run_one(-100000, d, got);
    tests++;
    if (!got || $signed(d) !== -11'sd1024 || overflow_cnt !== 16'd2) begin
      fails++;
      $display("FAIL sat_neg: got=%0b data=%0d ovf=%0d, want -1024 ovf=2", got, $signed(d), overflow_cnt);
    end
  endtask

  task automatic test_rounding;
    logic signed [ACCW-1:0] ins [4] = '{7, -7, 6, -8};
    logic signed [DW-1:0]   exps[4] = '{4, -3, 3, -4};
    logic [DW-1:0] d;
    bit got;
    set_cfg(0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      run_one(ins[i], d, got);
      tests++;
      if (!got || $signed(d) !== exps[i]) begin
        fails++;
        $display("FAIL round_%0d: in=%0d got=%0b data=%0d, want %0d", i, ins[i], got, $signed(d), exps[i]);
      end
    end
  endtask

  task automatic test_relu_bias;
    logic [DW-1:0] d;
    bit got;
    set_cfg(10, 0, 1);
    run_one(-50, d, got);
    tests++;
    if (!got || $signed(d) !== 11'sd0) begin
      fails++;
      $display("FAIL relu_neg: got=%0b data=%0d, want 0", got, $signed(d));
    end
    run_one(40, d, got);
    tests++;
    if (!got || $signed(d) !== 11'sd50) begin
      fails++;
      $display("FAIL relu_pos: got=%0b data=%0d, want 50", got, $signed(d));
    end
    set_cfg(10, 0, 0);
    run_one(-50, d, got);
    tests++;
    if (!got || $signed(d) !== -11'sd40) begin
      fails++;
      $display("FAIL norelu_neg: got=%0b data=%0d, want -40", got, $signed(d));
    end
  endtask

  task automatic test_backpressure;
    set_cfg(0, 0, 0);
    out_ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      acc_in = k; acc_valid = 1'b1;
      tick();
      tests++;
      if (drop !== (k >= 9)) begin
        fails++;
        $display("FAIL drop_sample_%0d: got %0b, want %0b", k, drop, (k >= 9));
      end
    end
    acc_valid = 1'b0;
    tick();
    tests++;
    if (drop !== 1'b0) begin
      fails++;
      $display("FAIL drop_pulse_end: got %0b, want 0", drop);
    end
    tick(); tick(); tick();
    tests++;
    if (fifo_full !== 1'b1 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL fifo_full: got full=%0b valid=%0b, want 1 1", fifo_full, out_valid);
    end
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tests++;
      if (out_valid !== 1'b1 || $signed(out_data) !== 11'(i)) begin
        fails++;
        $display("FAIL drain_%0d: got valid=%0b data=%0d, want 1 %0d", i, out_valid, $signed(out_data), i);
      end
      tick();
    end
    tests++;
    if (out_valid !== 1'b0 || fifo_full !== 1'b0 || $signed(out_data) !== 11'sd8) begin
      fails++;
      $display("FAIL drain_empty: got valid=%0b full=%0b data=%0d, want 0 0 8",
               out_valid, fifo_full, $signed(out_data));
    end
  endtask

  task automatic test_flush_and_reset;
    logic [DW-1:0] d;
    bit got;
    bit late;
    set_cfg(0, 2, 0);
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      acc_in = 40 + 4*k; acc_valid = 1'b1;
      tick();
    end
    acc_valid = 1'b0;
    tick(); tick(); tick(); tick();
    tests++;
    if (out_valid !== 1'b1 || $signed(out_data) !== 11'sd10) begin
      fails++;
      $display("FAIL queued_head: got valid=%0b data=%0d, want 1 10", out_valid, $signed(out_data));
    end
    acc_in = 56; acc_valid = 1'b1; tick();
    acc_in = 60; tick();
    acc_valid = 1'b0; rst_vals = 1'b1;
    tick();
    rst_vals = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || out_data !== '0 || fifo_full !== 1'b0) begin
      fails++;
      $display("FAIL flush: got valid=%0b data=%0d full=%0b, want 0 0 0", out_valid, out_data, fifo_full);
    end
    late = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid !== 1'b0) late = 1'b1;
    end
    tests++;
    if (late !== 1'b0) begin
      fails++;
      $display("FAIL flush_late_write: got out_valid after flush, want none");
    end
    out_ready = 1'b1;
    run_one(100, d, got);
    tests++;
    if (!got || $signed(d) !== 11'sd25 || overflow_cnt !== 16'd2) begin
      fails++;
      $display("FAIL retained_cfg: got=%0b data=%0d ovf=%0d, want 25 ovf=2", got, $signed(d), overflow_cnt);
    end

    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      acc_in = 7; acc_valid = 1'b1;
      tick();
    end
    acc_valid = 1'b0;
    tick();
    #2 rst_overall = 1'b1;
    #1;
    tests++;
    if ({out_data, out_valid, fifo_full, drop, overflow_cnt} !== '0) begin
      fails++;
      $display("FAIL async_reset: got data=%0d valid=%0b full=%0b drop=%0b ovf=%0d, want all 0",
               out_data, out_valid, fifo_full, drop, overflow_cnt);
    end
    @(negedge clk) rst_overall = 1'b0;
    late = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (out_valid !== 1'b0) late = 1'b1;
    end
    tests++;
    if (late !== 1'b0) begin
      fails++;
      $display("FAIL reset_late_write: got out_valid after reset, want none");
    end
    out_ready = 1'b1;
    run_one(7, d, got);
    tests++;
    if (!got || $signed(d) !== 11'sd7) begin
      fails++;
      $display("FAIL cfg_cleared: got=%0b data=%0d, want 7 (shift 0)", got, $signed(d));
    end
  endtask

  initial begin
    test_reset();
    test_passthrough_latency();
    test_saturation();
    test_rounding();
    test_relu_bias();
    test_backpressure();
    test_flush_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
